// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared MMC3 mapper definitions: IRQ register decode, save-state offsets and bus type.
package mmc3_scanline_irq_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FLT_W  = 2;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [REG_W-1:0] IRQ_LATCH  = 4'hC;
  localparam logic [REG_W-1:0] IRQ_RELOAD = 4'hD;
  localparam logic [REG_W-1:0] IRQ_OFF    = 4'hE;
  localparam logic [REG_W-1:0] IRQ_ON     = 4'hF;

  localparam logic [7:0] SST_IRQ_BASE  = 8'd16;
  localparam logic [7:0] SST_IRQ_LATCH = 8'd16;
  localparam logic [7:0] SST_IRQ_CNT   = 8'd17;
  localparam logic [7:0] SST_IRQ_CTRL  = 8'd18;
  localparam logic [7:0] SST_IRQ_FLT   = 8'd19;

  typedef struct packed {
    logic             act_mc;
    logic             we_reg;
    logic [7:0]       addr;
    logic [DATA_W-1:0] dato;
  } SSTBus;

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// CPU/PPU/save-state signal bundle between the mapper top and the scanline IRQ unit.
interface mmc3_scanline_irq_if;
  import mmc3_scanline_irq_pkg::*;

  logic              cpu_m3;
  logic              cpu_m2;
  logic              cpu_rw;
  logic [DATA_W-1:0] cpu_data;
  logic [REG_W-1:0]  reg_addr;
  logic              ppu_a12;
  logic              mmc3a;
  SSTBus             sst;
  logic              irq;
  logic [DATA_W-1:0] sst_di;

  modport master (
    output cpu_m3, cpu_m2, cpu_rw, cpu_data, reg_addr, ppu_a12, mmc3a, sst,
    input  irq, sst_di
  );

  modport slave (
    input  cpu_m3, cpu_m2, cpu_rw, cpu_data, reg_addr, ppu_a12, mmc3a, sst,
    output irq, sst_di
  );
endinterface

// File: rtl/mmc3_scanline_irq_a12_filter.sv
// PPU A12 rise filter: a rise counts only after A12 stayed low for three M2 falling edges.
module mmc3_a12_filter
  import mmc3_scanline_irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ppu_a12,
  input  logic             cpu_m2,
  input  logic             freeze,
  input  logic             flt_ld,
  input  logic [FLT_W-1:0] flt_ld_val,
  output logic             clk_ev_c,
  output logic [FLT_W-1:0] flt
);

  localparam logic [FLT_W-1:0] FLT_MAX = '1;

  logic a12_q;
  logic m2_q;

  // Edge samplers keep running while frozen so leaving a restore never fakes an edge.
  always_ff @(posedge clk) begin
    a12_q <= ppu_a12;
    m2_q  <= cpu_m2;
    if (rst) begin
      flt <= '0;
    end else if (flt_ld) begin
      flt <= flt_ld_val;
    end else if (!freeze) begin
      if (a12_q) begin
        flt <= '0;
      end else if (m2_q && !cpu_m2 && (flt != FLT_MAX)) begin
        flt <= flt + FLT_W'(1);
      end
    end
  end

  assign clk_ev_c = ppu_a12 & ~a12_q & (flt == FLT_MAX) & ~freeze;

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ: latch/reload/decrement counter clocked by filtered A12 rises,
// MMC3A/MMC3B zero-trigger rules, and save-state access at offsets 16..19.
module mmc3_scanline_irq
  import mmc3_scanline_irq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mmc3_scanline_irq_if.slave   bus
);

  logic [CNT_W-1:0] latch, latch_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             reload, reload_n;
  logic             irq_on, irq_on_n;
  logic             pend, pend_n;
  logic [CNT_W-1:0] cnt_ev;
  logic             trig;
  logic             clk_ev_c;
  logic [FLT_W-1:0] flt;

  logic cpu_wr, sst_wr;
  logic wr_latch, wr_reload, wr_off, wr_on;

  assign cpu_wr    = bus.cpu_m3 & ~bus.cpu_rw & ~bus.sst.act_mc;
  assign sst_wr    = bus.cpu_m3 & bus.sst.we_reg & bus.sst.act_mc;
  assign wr_latch  = cpu_wr & (bus.reg_addr == IRQ_LATCH);
  assign wr_reload = cpu_wr & (bus.reg_addr == IRQ_RELOAD);
  assign wr_off    = cpu_wr & (bus.reg_addr == IRQ_OFF);
  assign wr_on     = cpu_wr & (bus.reg_addr == IRQ_ON);

  mmc3_a12_filter u_filter (
    .clk        (clk),
    .rst        (rst),
    .ppu_a12    (bus.ppu_a12),
    .cpu_m2     (bus.cpu_m2),
    .freeze     (bus.sst.act_mc),
    .flt_ld     (sst_wr && (bus.sst.addr == SST_IRQ_FLT)),
    .flt_ld_val (bus.sst.dato[FLT_W-1:0]),
    .clk_ev_c   (clk_ev_c),
    .flt        (flt)
  );

  // Next-state: D discards a coincident clock, E beats a coincident trigger.
  always_comb begin
    latch_n  = latch;
    cnt_n    = cnt;
    reload_n = reload;
    irq_on_n = irq_on;
    pend_n   = pend;
    cnt_ev   = ((cnt == '0) || reload) ? latch : cnt - CNT_W'(1);
    trig     = (cnt_ev == '0) && (!bus.mmc3a || (cnt != '0) || reload);

    if (sst_wr) begin
      case (bus.sst.addr)
        SST_IRQ_LATCH: latch_n = bus.sst.dato;
        SST_IRQ_CNT:   cnt_n   = bus.sst.dato;
        SST_IRQ_CTRL:  {reload_n, irq_on_n, pend_n} = bus.sst.dato[2:0];
        default: ;
      endcase
    end else begin
      if (clk_ev_c && !wr_reload) begin
        cnt_n    = cnt_ev;
        reload_n = 1'b0;
        if (trig && irq_on) pend_n = 1'b1;
      end
      if (wr_latch) latch_n = bus.cpu_data;
      if (wr_reload) begin
        cnt_n    = '0;
        reload_n = 1'b1;
      end
      if (wr_off) begin
        irq_on_n = 1'b0;
        pend_n   = 1'b0;
      end
      if (wr_on) irq_on_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch  <= '0;
      cnt    <= '0;
      reload <= 1'b0;
      irq_on <= 1'b0;
      pend   <= 1'b0;
    end else begin
      latch  <= latch_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      irq_on <= irq_on_n;
      pend   <= pend_n;
    end
  end

  assign bus.irq = pend;

  always_comb begin
    case (bus.sst.addr)
      SST_IRQ_LATCH: bus.sst_di = latch;
      SST_IRQ_CNT:   bus.sst_di = cnt;
      SST_IRQ_CTRL:  bus.sst_di = {5'b0, reload, irq_on, pend};
      SST_IRQ_FLT:   bus.sst_di = {6'b0, flt};
      default:       bus.sst_di = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Scoreboard bench for mmc3_scanline_irq: directed stimulus queues expected
// {irq, sst_di} pairs that a negedge monitor pops and compares.
module tb_mmc3_scanline_irq;
  import mmc3_scanline_irq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmc3_scanline_irq_if bus();

  mmc3_scanline_irq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [8*20-1:0] name;
    logic [7:0]      di;
    logic            irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic chk_req = 1'b0;

  // Monitor: pops one expectation whenever the stimulus presents a sample point.
  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sample_without_expectation at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if ((bus.sst_di !== e.di) || (bus.irq !== e.irq)) begin
          n_fail++;
          $display("FAIL %0s: got sst_di=%02h irq=%b, want sst_di=%02h irq=%b",
                   e.name, bus.sst_di, bus.irq, e.di, e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [8*20-1:0] name, input logic [7:0] addr,
                     input logic [7:0] di, input logic irq);
    exp_t e;
    bus.sst.addr = addr;
    e.name = name;
    e.di   = di;
    e.irq  = irq;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.cpu_m3 = 1'b1; bus.cpu_rw = 1'b0; bus.reg_addr = a; bus.cpu_data = d;
    tick();
    bus.cpu_m3 = 1'b0; bus.cpu_rw = 1'b1;
  endtask

  task automatic m2_falls(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cpu_m2 = 1'b1; tick();
      bus.cpu_m2 = 1'b0; tick();
    end
  endtask

  task automatic rise();
    bus.ppu_a12 = 1'b1; tick();
    bus.ppu_a12 = 1'b0; tick();
  endtask

  // Register write landing on the same edge as an A12 rise.
  task automatic rise_wr(input logic [3:0] a, input logic [7:0] d);
    bus.ppu_a12 = 1'b1;
    wr(a, d);
    bus.ppu_a12 = 1'b0; tick();
  endtask

  task automatic sst_ld(input logic [7:0] a, input logic [7:0] d);
    bus.sst.addr = a; bus.sst.dato = d; bus.sst.we_reg = 1'b1; bus.cpu_m3 = 1'b1;
    tick();
    bus.sst.we_reg = 1'b0; bus.cpu_m3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.cpu_m3 = 1'b0; bus.cpu_m2 = 1'b0; bus.cpu_rw = 1'b1;
    bus.cpu_data = 8'h00; bus.reg_addr = 4'h0; bus.ppu_a12 = 1'b0; bus.mmc3a = 1'b0;
    bus.sst = '0;
    tick(); tick();
    chk("rst_latch", 8'd16, 8'h00, 1'b0);
    chk("rst_ctrl",  8'd18, 8'h00, 1'b0);
    rst = 1'b0;
    tick();

    // Counting: latch 3, reload, enable, four filtered rises.
    wr(IRQ_LATCH, 8'd3); wr(IRQ_RELOAD, 8'h00); wr(IRQ_ON, 8'h00);
    chk("cnt_setup_cnt",  8'd17, 8'h00, 1'b0);
    chk("cnt_setup_ctrl", 8'd18, 8'h06, 1'b0);
    m2_falls(3); rise(); chk("cnt_rise1", 8'd17, 8'd3, 1'b0);
    m2_falls(3); rise(); chk("cnt_rise2", 8'd17, 8'd2, 1'b0);
    m2_falls(4); rise(); chk("cnt_rise3", 8'd17, 8'd1, 1'b0);
    m2_falls(3); rise(); chk("cnt_rise4", 8'd17, 8'd0, 1'b1);
    chk("cnt_rise4_ctrl", 8'd18, 8'h03, 1'b1);
    wr(IRQ_OFF, 8'h00);
    chk("cnt_ack", 8'd18, 8'h00, 1'b0);

    // Filter: two low M2 falls are not enough.
    m2_falls(2); rise(); chk("flt_2falls", 8'd17, 8'd0, 1'b0);
    m2_falls(3); rise(); chk("flt_3falls_reload", 8'd17, 8'd3, 1'b0);
    m2_falls(2); rise(); chk("flt_2falls_hold", 8'd17, 8'd3, 1'b0);
    m2_falls(3); rise(); chk("flt_3falls_dec", 8'd17, 8'd2, 1'b0);
    m2_falls(5); chk("flt_saturate", 8'd19, 8'd3, 1'b0);
    rise();

    // MMC3B with latch 0 fires on every edge.
    bus.mmc3a = 1'b0;
    wr(IRQ_LATCH, 8'd0); wr(IRQ_RELOAD, 8'h00); wr(IRQ_ON, 8'h00);
    m2_falls(3); rise(); chk("b_rise1", 8'd17, 8'd0, 1'b1);
    wr(IRQ_OFF, 8'h00); wr(IRQ_ON, 8'h00);
    chk("b_reack", 8'd18, 8'h02, 1'b0);
    m2_falls(3); rise(); chk("b_rise2", 8'd17, 8'd0, 1'b1);

    // MMC3A with latch 0 fires only after the reload.
    wr(IRQ_OFF, 8'h00);
    bus.mmc3a = 1'b1;
    wr(IRQ_RELOAD, 8'h00); wr(IRQ_ON, 8'h00);
    m2_falls(3); rise(); chk("a_rise1", 8'd18, 8'h03, 1'b1);
    wr(IRQ_OFF, 8'h00); wr(IRQ_ON, 8'h00);
    m2_falls(3); rise(); chk("a_rise2", 8'd18, 8'h02, 1'b0);
    bus.mmc3a = 1'b0;

    // Collisions.
    wr(IRQ_OFF, 8'h00); wr(IRQ_LATCH, 8'd5); wr(IRQ_RELOAD, 8'h00); wr(IRQ_ON, 8'h00);
    m2_falls(3); rise(); chk("col_cnt5", 8'd17, 8'd5, 1'b0);
    m2_falls(3); rise_wr(IRQ_RELOAD, 8'h00);
    chk("col_d_cnt",  8'd17, 8'd0, 1'b0);
    chk("col_d_ctrl", 8'd18, 8'h06, 1'b0);
    wr(IRQ_LATCH, 8'd0);
    m2_falls(3); rise_wr(IRQ_OFF, 8'h00);
    chk("col_e_ctrl", 8'd18, 8'h00, 1'b0);
    wr(IRQ_LATCH, 8'd7);
    m2_falls(3); rise_wr(IRQ_LATCH, 8'd9);
    chk("col_c_cnt",   8'd17, 8'd7, 1'b0);
    chk("col_c_latch", 8'd16, 8'd9, 1'b0);

    // Save-state restore under act_mc; a qualifying rise while frozen must not clock.
    bus.sst.act_mc = 1'b1;
    sst_ld(8'd16, 8'h20); sst_ld(8'd17, 8'h07); sst_ld(8'd18, 8'h07); sst_ld(8'd19, 8'h03);
    chk("sst_latch", 8'd16, 8'h20, 1'b1);
    chk("sst_cnt",   8'd17, 8'h07, 1'b1);
    chk("sst_ctrl",  8'd18, 8'h07, 1'b1);
    chk("sst_flt",   8'd19, 8'h03, 1'b1);
    rise();
    chk("sst_frozen_cnt", 8'd17, 8'h07, 1'b1);
    chk("sst_frozen_flt", 8'd19, 8'h03, 1'b1);
    bus.sst.act_mc = 1'b0;
    tick();
    chk("sst_exit_cnt", 8'd17, 8'h07, 1'b1);

    // Reset mid-count with irq pending.
    wr(IRQ_LATCH, 8'd4); wr(IRQ_RELOAD, 8'h00);
    m2_falls(3); rise(); chk("pre_rst_cnt", 8'd17, 8'd4, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid_latch", 8'd16, 8'h00, 1'b0);
    chk("rst_mid_cnt",   8'd17, 8'h00, 1'b0);
    chk("rst_mid_ctrl",  8'd18, 8'h00, 1'b0);
    chk("rst_mid_flt",   8'd19, 8'h00, 1'b0);
    chk("rd_other_addr", 8'd20, 8'hFF, 1'b0);
    rst = 1'b0;
    tick();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unconsumed_expectations: got %0d left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmc3_scanline_irq.md
# mmc3_scanline_irq

Scanline IRQ unit for MMC3-family mappers. It sits directly downstream of the MMC3 register decoder and consumes the decoded CPU register strobe, the data bus and PPU A12. It produces the registered IRQ pending flag that the mapper top inverts onto the cartridge IRQ line. It filters A12 rising edges, maintains the 8-bit reload/decrement counter, supports the MMC3A and MMC3B zero-trigger variants, and exposes its state on the save-state bus at offsets 16..19.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all logic is clocked on posedge clk.
- rst  in  1  reset, synchronous, active-high (driven from map_rst).
- cpu_m3  in  1  one-clk strobe per CPU cycle; qualifies register writes.
- cpu_m2  in  1  CPU M2 level, synchronous to clk.
- cpu_rw  in  1  CPU R/W; a write is cpu_m3 & !cpu_rw.
- cpu_data  in  8  CPU data bus.
- reg_addr  in  4  {!cpu_ce_n, A14, A13, A0}. Decodes: 4'hC = latch, 4'hD = reload, 4'hE = disable/ack, 4'hF = enable.
- ppu_a12  in  1  PPU A12 level, synchronous to clk.
- mmc3a  in  1  1 = MMC3A zero-trigger rule; 0 = MMC3B.
- sst  in  SSTBus  save-state bus; uses fields act_mc, we_reg, addr[7:0], dato[7:0].
- irq  out  1  IRQ pending, active-high, registered.
- sst_di  out  8  save-state readback.

## Operation
- State:
  - latch[7:0]
  - cnt[7:0]
  - reload (1 bit)
  - irq_on (1 bit)
  - pend (1 bit)
  - flt[1:0]: A12-low M2 falling-edge count, saturating at 3
  - a12_q, m2_q: previous-sample registers
- A12 filter:
  - While a12_q is 0, each M2 falling edge (m2_q & !cpu_m2) increments flt, saturating at 3.
  - a12_q = 1 sets flt to 0.
  - An A12 rise is ppu_a12 & !a12_q.
  - A rise produces a counter clock (clk_ev) only if flt == 3 at that sample. Rises with flt < 3 are ignored.
- Counter on clk_ev:
  - If cnt == 0 or reload = 1: cnt ← latch and reload ← 0. Otherwise cnt ← cnt − 1.
  - Trigger with MMC3B: new cnt == 0.
  - Trigger with MMC3A: new cnt == 0 and (old cnt != 0 or reload was 1).
  - If the trigger holds and irq_on = 1, then pend ← 1.
- Register writes (cpu_m3 & !cpu_rw):
  - C: latch ← cpu_data.
  - D: cnt ← 0, reload ← 1.
  - E: irq_on ← 0, pend ← 0.
  - F: irq_on ← 1. pend is unchanged.
- irq = pend. Pend is cleared only by an E write or by rst.
- Save-state readback, sst_di:
  - addr 16: latch
  - addr 17: cnt
  - addr 18: {5'b0, reload, irq_on, pend}
  - addr 19: {6'b0, flt}
  - any other addr: 8'hFF
- Save-state restore:
  - When sst.act_mc = 1, normal updates are frozen and clk_ev is suppressed.
  - On cpu_m3 & sst.we_reg, addresses 16..19 load from sst.dato using the same bit map as readback.
  - a12_q and m2_q continue sampling so no spurious edge appears on exit.
- Reset: latch, cnt, reload, irq_on, pend and flt all 0. a12_q and m2_q take the current inputs. irq = 0.

## Timing
- Edge detect latency: ppu_a12 sampled high at edge N with a12_q = 0 and flt = 3. cnt and pend update at edge N. irq is visible after edge N.
- Register write latency: the write takes effect at the clk edge where cpu_m3 is high. irq drops after that same edge for an E write.
- Simultaneous events in the same clk (priority order):
  1. rst overrides everything.
  2. A D write discards clk_ev: cnt = 0, reload = 1, no trigger.
  3. A C write with clk_ev: the counter reload uses the old latch; latch then takes the new value.
  4. An E write with a trigger: pend = 0 and irq_on = 0 (E wins).
  5. An F write with a trigger: pend follows the old irq_on.
- Wrap-around: there is none. A clock at cnt == 0 always reloads, never decrements to 255.
- Latch = 0 case:
  - MMC3B: fires on every filtered edge.
  - MMC3A: fires only on the first edge after a D write.
- rst mid-count: returns all state to the reset values on the next edge.

## Structure
- The shared mapper package holds:
  - register decode constants IRQ_LATCH = 4'hC, IRQ_RELOAD = 4'hD, IRQ_OFF = 4'hE, IRQ_ON = 4'hF
  - save-state offsets SST_IRQ_BASE = 16 through 19
- SSTBus is the existing package typedef.
- One sub-module: mmc3_a12_filter, which owns flt, a12_q and m2_q and outputs clk_ev and flt for save-state use.

## Test plan
- Counting: latch = 3, D write, F write, then filtered A12 rises (≥3 M2 falls low each).
  - Required: cnt goes 3, 2, 1, 0; irq asserts on the 4th rise; an E write clears it on that edge.
- Filter: A12 low for only 2 M2 falls, then rise.
  - Required: cnt unchanged. With 3 falls, cnt decrements.
- Variant: latch = 0, reload, enable, two rises.
  - Required with mmc3a = 0: irq after rise 1, and after rise 2 once re-acked.
  - Required with mmc3a = 1: irq after rise 1 only.
- Collisions:
  - D write on the same clk as a rise with cnt = 5: cnt = 0, reload = 1, irq stays 0.
  - E write on the same clk as a triggering rise: irq = 0.
- Save-state: write 16..19 = 8'h20, 8'h07, 8'h07, 8'h03 under act_mc with cpu_m3.
  - Required: readback matches, irq = 1, and no clk_ev occurs during act_mc.
- Reset mid-count: assert rst with cnt = 4 and irq = 1.
  - Required: all readbacks are 0 and irq = 0 on the next edge.
